// File: rtl/beta_pkg.sv
// beta_pkg: Beta ISA opcodes, substitute instructions, decode control bundle and opcode legality.
package beta_pkg;
    localparam logic [5:0] OP_LD    = 6'h18, OP_ST    = 6'h19, OP_JMP   = 6'h1B, OP_BEQ   = 6'h1D;
    localparam logic [5:0] OP_BNE   = 6'h1E, OP_LDR   = 6'h1F;
    localparam logic [5:0] OP_ADD   = 6'h20, OP_SUB   = 6'h21, OP_MUL   = 6'h22, OP_DIV   = 6'h23;
    localparam logic [5:0] OP_CMPEQ = 6'h24, OP_CMPLT = 6'h25, OP_CMPLE = 6'h26, OP_AND   = 6'h28;
    localparam logic [5:0] OP_OR    = 6'h29, OP_XOR   = 6'h2A, OP_XNOR  = 6'h2B, OP_SHL   = 6'h2C;
    localparam logic [5:0] OP_SHR   = 6'h2D, OP_SRA   = 6'h2E;
    localparam logic [5:0] OP_ADDC  = 6'h30, OP_SUBC  = 6'h31, OP_MULC  = 6'h32, OP_DIVC  = 6'h33;
    localparam logic [5:0] OP_CMPEQC = 6'h34, OP_CMPLTC = 6'h35, OP_CMPLEC = 6'h36, OP_ANDC = 6'h38;
    localparam logic [5:0] OP_ORC   = 6'h39, OP_XORC  = 6'h3A, OP_XNORC = 6'h3B, OP_SHLC  = 6'h3C;
    localparam logic [5:0] OP_SHRC  = 6'h3D, OP_SRAC  = 6'h3E;
    // ADD(R31,R31,R31) and BNE(R31,0,XP)
    localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h7BDF_0000;
    typedef struct packed {
        logic ld, st, ldr, jmp, beq, bne, wr_link, illegal, exc;
    } dec_ctl_t;
    function automatic logic is_legal(input logic [5:0] op);
        return (op inside {OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR}) || (op[5] && op[2:0] != 3'b111);
    endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32-entry register file, two read ports, one write port, R31 reads zero, write-through.
module regfile_2r1w #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] mem [32];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        else if (we && wa != 5'd31)
            mem[wa] <= wd;
    end
    assign rd1 = (ra1 == 5'd31) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
    assign rd2 = (ra2 == 5'd31) ? '0 : (we && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: decode stage with valid/ready handshakes, N-deep bypass with load-use interlock,
// in-stage branch resolution, flush, latched interrupt injection and illegal-opcode trapping.
module decode_stage_p import beta_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int NBYP  = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [31:0]          if_ir,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [XLEN-1:0]      id_pc,
    output logic [31:0]          id_ir,
    output logic [XLEN-1:0]      id_a,
    output logic [XLEN-1:0]      id_b,
    output logic [XLEN-1:0]      id_d,
    output dec_ctl_t             id_ctl,
    input  logic                 flush,
    input  logic                 irq,
    output logic                 redirect_vld,
    output logic [XLEN-1:0]      redirect_pc,
    input  logic [NBYP-1:0]      byp_vld,
    input  logic [NBYP*5-1:0]    byp_rc,
    input  logic [NBYP-1:0]      byp_ld,
    input  logic [NBYP*XLEN-1:0] byp_data,
    input  logic                 wb_we,
    input  logic [4:0]           wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic [CNT_W-1:0]     stall_cnt
);
    logic            dec_vld, irq_pend, stall, fire, is_op, is_opc, is_st, sub, taken, lu_a, lu_p;
    logic [XLEN-1:0] dec_pc, sxt, br_tgt, rf_a, rf_p, val_a, val_p, op_a, op_p;
    logic [31:0]     dec_ir;
    logic [5:0]      opc;
    logic [4:0]      rc, ra, rb, rp;
    logic [NBYP-1:0] hit_a, hit_p, ld_use;
    assign opc    = dec_ir[31:26];
    assign rc     = dec_ir[25:21];
    assign ra     = dec_ir[20:16];
    assign rb     = dec_ir[15:11];
    assign is_op  = opc[5:4] == 2'b10;
    assign is_opc = opc[5:4] == 2'b11;
    assign is_st  = opc == OP_ST;
    assign rp     = is_st ? rc : rb;
    assign sxt    = {{(XLEN-16){dec_ir[15]}}, dec_ir[15:0]};
    assign br_tgt = dec_pc + XLEN'(4) + {sxt[XLEN-3:0], 2'b00};
    regfile_2r1w #(.XLEN(XLEN)) u_rf (
        .clk(clk), .rst_n(rst_n), .ra1(ra), .rd1(rf_a), .ra2(rp), .rd2(rf_p),
        .we(wb_we), .wa(wb_addr), .wd(wb_data)
    );
    // Write-back stage (last) always has its result ready, so it never interlocks.
    for (genvar k = 0; k < NBYP; k++) begin : g_byp
        assign hit_a[k]  = byp_vld[k] && byp_rc[k*5 +: 5] == ra;
        assign hit_p[k]  = byp_vld[k] && byp_rc[k*5 +: 5] == rp;
        assign ld_use[k] = byp_ld[k] && (k < NBYP - 1);
    end
    always_comb begin
        val_a = rf_a;
        val_p = rf_p;
        lu_a  = 1'b0;
        lu_p  = 1'b0;
        for (int i = NBYP - 1; i >= 0; i--) begin
            val_a = hit_a[i] ? byp_data[i*XLEN +: XLEN] : val_a;
            lu_a  = hit_a[i] ? ld_use[i] : lu_a;
            val_p = hit_p[i] ? byp_data[i*XLEN +: XLEN] : val_p;
            lu_p  = hit_p[i] ? ld_use[i] : lu_p;
        end
    end
    assign op_a     = (ra == 5'd31) ? '0 : val_a;
    assign op_p     = (rp == 5'd31) ? '0 : val_p;
    assign stall    = dec_vld && !flush && ((ra != 5'd31 && lu_a) || ((is_op || is_st) && rp != 5'd31 && lu_p));
    assign id_valid = dec_vld && !stall && !flush;
    assign if_ready = !flush && (!dec_vld || (id_ready && !stall));
    assign fire     = id_valid && id_ready;
    assign sub      = irq_pend || !is_legal(opc);
    assign id_pc    = dec_pc;
    assign id_ir    = sub ? INST_BNE_EXCEPT : dec_ir;
    assign id_ctl   = irq_pend ? dec_ctl_t'{wr_link: 1'b1, exc: 1'b1, default: 1'b0} :
                      sub      ? dec_ctl_t'{wr_link: 1'b1, illegal: 1'b1, default: 1'b0} :
                                 dec_ctl_t'{ld: opc == OP_LD, st: is_st, ldr: opc == OP_LDR, jmp: opc == OP_JMP,
                                            beq: opc == OP_BEQ, bne: opc == OP_BNE,
                                            wr_link: opc inside {OP_JMP, OP_BEQ, OP_BNE}, default: 1'b0};
    assign id_a     = (opc == OP_LDR) ? br_tgt : op_a;
    assign id_b     = (is_opc || opc == OP_LD || is_st) ? sxt : op_p;
    assign id_d     = is_st ? op_p : '0;
    assign taken    = !sub && (opc == OP_JMP || (opc == OP_BEQ && op_a == '0) || (opc == OP_BNE && op_a != '0));
    assign redirect_vld = fire && taken;
    assign redirect_pc  = (opc == OP_JMP) ? {op_a[XLEN-1:2], 2'b00} : br_tgt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_vld   <= 1'b0;
            dec_pc    <= '0;
            dec_ir    <= INST_NOP;
            irq_pend  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            dec_vld   <= (if_valid && if_ready) || (dec_vld && !fire && !flush);
            dec_pc    <= (if_valid && if_ready) ? if_pc : dec_pc;
            dec_ir    <= (if_valid && if_ready) ? if_ir : dec_ir;
            irq_pend  <= irq || (irq_pend && !fire);
            stall_cnt <= stall_cnt + CNT_W'(stall && !(&stall_cnt));
        end
    end
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the decode slot, register file, interrupt latch and stall counter.
module tb_decode_stage_p;
    import beta_pkg::*;
    localparam int XLEN = 32, NBYP = 3, CNT_W = 16;
    localparam logic [31:0] NOP_IR = 32'h83FF_F800, EXC_IR = 32'h7BDF_0000;
    localparam logic [31:0] ADD123 = 32'h8022_1800, ADD777 = 32'h80E7_3800;
    localparam logic [31:0] BEQ_M1 = 32'h74A0_FFFF, BNE_M1 = 32'h78A0_FFFF;
    localparam logic [5:0] OPS [14] = '{6'h18, 6'h19, 6'h1B, 6'h1D, 6'h1E, 6'h1F, 6'h20,
                                        6'h21, 6'h2A, 6'h30, 6'h31, 6'h3E, 6'h00, 6'h27};
    logic clk = 1'b0, rst_n = 1'b1;
    logic if_valid, if_ready, id_valid, id_ready, flush, irq, redirect_vld, wb_we;
    logic [XLEN-1:0] if_pc, id_pc, id_a, id_b, id_d, redirect_pc, wb_data;
    logic [31:0] if_ir, id_ir;
    dec_ctl_t id_ctl;
    logic [NBYP-1:0] byp_vld, byp_ld;
    logic [NBYP*5-1:0] byp_rc;
    logic [NBYP*XLEN-1:0] byp_data;
    logic [4:0] wb_addr;
    logic [CNT_W-1:0] stall_cnt;
    logic s_if_ready, s_id_valid, s_redirect_vld;
    logic [XLEN-1:0] s_id_pc, s_id_a, s_id_b, s_id_d, s_redirect_pc;
    logic [31:0] s_id_ir;
    dec_ctl_t s_id_ctl;
    logic [1:0] s_stall_cnt;
    logic [XLEN-1:0] m_rf [32];
    logic [XLEN-1:0] m_pc;
    logic [31:0] m_ir;
    bit m_vld, m_pend;
    int m_cnt, n_vec, n_err;
    always #5 clk = ~clk;
    decode_stage_p #(.XLEN(XLEN), .NBYP(NBYP), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_ir(if_ir),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_ir(id_ir), .id_a(id_a), .id_b(id_b),
        .id_d(id_d), .id_ctl(id_ctl), .flush(flush), .irq(irq), .redirect_vld(redirect_vld),
        .redirect_pc(redirect_pc), .byp_vld(byp_vld), .byp_rc(byp_rc), .byp_ld(byp_ld), .byp_data(byp_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall_cnt(stall_cnt)
    );
    // Narrow-counter build sees the same traffic so saturation is reachable.
    decode_stage_p #(.XLEN(XLEN), .NBYP(NBYP), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(s_if_ready), .if_pc(if_pc), .if_ir(if_ir),
        .id_valid(s_id_valid), .id_ready(id_ready), .id_pc(s_id_pc), .id_ir(s_id_ir), .id_a(s_id_a),
        .id_b(s_id_b), .id_d(s_id_d), .id_ctl(s_id_ctl), .flush(flush), .irq(irq),
        .redirect_vld(s_redirect_vld), .redirect_pc(s_redirect_pc), .byp_vld(byp_vld), .byp_rc(byp_rc),
        .byp_ld(byp_ld), .byp_data(byp_data), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_cnt(s_stall_cnt)
    );
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    function automatic void resolve(input logic [4:0] r, output logic [XLEN-1:0] v, output bit lu);
        v = (wb_we && wb_addr == r) ? wb_data : m_rf[r];
        lu = 0;
        if (r == 5'd31) begin
            v = '0;
            return;
        end
        for (int k = 0; k < NBYP; k++)
            if (byp_vld[k] && byp_rc[k*5 +: 5] == r) begin
                v = byp_data[k*XLEN +: XLEN];
                lu = byp_ld[k] && k < NBYP - 1;
                return;
            end
    endfunction
    task automatic model_reset();
        foreach (m_rf[i]) m_rf[i] = '0;
        m_vld = 0; m_pend = 0; m_cnt = 0; m_pc = '0; m_ir = NOP_IR;
    endtask
    task automatic idle();
        if_valid = 0; if_pc = '0; if_ir = '0; id_ready = 1; flush = 0; irq = 0;
        byp_vld = '0; byp_rc = '0; byp_ld = '0; byp_data = '0; wb_we = 0; wb_addr = '0; wb_data = '0;
    endtask
    task automatic do_reset();
        rst_n = 0;
        #2;
        check_val("rst id_valid", id_valid, 0);
        check_val("rst redirect_vld", redirect_vld, 0);
        check_val("rst stall_cnt", stall_cnt, 0);
        check_val("rst id_ir", id_ir, NOP_IR);
        check_val("rst id_pc", id_pc, 0);
        check_val("rst sat stall_cnt", s_stall_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask
    task automatic step();
        logic [5:0] op;
        logic [4:0] rc, ra, rb, rp;
        logic [XLEN-1:0] sxt, tgt, av, pv;
        logic [8:0] e_ctl;
        bit lua, lup, legal, st, is_alu, stall, e_idv, e_ifr, fire, taken;
        #4;
        op = m_ir[31:26]; rc = m_ir[25:21]; ra = m_ir[20:16]; rb = m_ir[15:11];
        st = op == 6'h19;
        is_alu = op >= 6'h20 && op < 6'h30;
        rp = st ? rc : rb;
        sxt = {{16{m_ir[15]}}, m_ir[15:0]};
        tgt = m_pc + 4 + sxt * 4;
        legal = (op inside {6'h18, 6'h19, 6'h1B, 6'h1D, 6'h1E, 6'h1F}) || (op >= 6'h20 && op % 8 != 7);
        resolve(ra, av, lua);
        resolve(rp, pv, lup);
        stall = m_vld && !flush && (lua || ((is_alu || st) && lup));
        e_idv = m_vld && !stall && !flush;
        e_ifr = !flush && (!m_vld || (id_ready && !stall));
        fire = e_idv && id_ready;
        e_ctl = m_pend ? 9'b0_0000_0101 : !legal ? 9'b0_0000_0110 :
                {op == 6'h18, st, op == 6'h1F, op == 6'h1B, op == 6'h1D, op == 6'h1E,
                 op == 6'h1B || op == 6'h1D || op == 6'h1E, 2'b00};
        taken = !m_pend && legal && (op == 6'h1B || (op == 6'h1D && av == 0) || (op == 6'h1E && av != 0));
        check_val("id_valid", id_valid, e_idv);
        check_val("if_ready", if_ready, e_ifr);
        check_val("redirect_vld", redirect_vld, fire && taken);
        check_val("stall_cnt", stall_cnt, m_cnt);
        check_val("sat stall_cnt", s_stall_cnt, m_cnt > 3 ? 3 : m_cnt);
        if (m_vld) begin
            check_val("id_pc", id_pc, m_pc);
            check_val("id_ir", id_ir, (m_pend || !legal) ? EXC_IR : m_ir);
            check_val("id_ctl", id_ctl, e_ctl);
        end
        if (e_idv) begin
            check_val("id_a", id_a, op == 6'h1F ? tgt : av);
            check_val("id_b", id_b, (op >= 6'h30 || op == 6'h18 || st) ? sxt : pv);
            check_val("id_d", id_d, st ? pv : 0);
        end
        if (fire && taken) check_val("redirect_pc", redirect_pc, op == 6'h1B ? av & ~32'd3 : tgt);
        if (stall && m_cnt < 2**CNT_W - 1) m_cnt++;
        m_pend = irq || (m_pend && !fire);
        if (if_valid && e_ifr) begin
            m_vld = 1; m_pc = if_pc; m_ir = if_ir;
        end else if (fire || flush) m_vld = 0;
        if (wb_we && wb_addr != 5'd31) m_rf[wb_addr] = wb_data;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 4));
        return r == 5'd4 ? 5'd31 : r;
    endfunction
    task automatic rand_in();
        if_valid = $urandom_range(0, 9) < 7;
        if_pc = 32'($urandom_range(0, 1023)) << 2;
        if_ir = {OPS[$urandom_range(0, 13)], pick_reg(), pick_reg(), pick_reg(), 11'($urandom)};
        id_ready = $urandom_range(0, 3) != 0;
        flush = $urandom_range(0, 19) == 0;
        irq = $urandom_range(0, 29) == 0;
        for (int k = 0; k < NBYP; k++) begin
            byp_vld[k] = $urandom_range(0, 2) == 0;
            byp_ld[k] = $urandom_range(0, 2) == 0;
            byp_rc[k*5 +: 5] = pick_reg();
            byp_data[k*XLEN +: XLEN] = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
        end
        wb_we = $urandom_range(0, 1) == 1;
        wb_addr = pick_reg();
        wb_data = $urandom;
    endtask
    initial begin
        n_vec = 0; n_err = 0;
        idle();
        #1;
        do_reset();
        // bypass from exec, not a load
        if_valid = 1; if_pc = 32'h40; if_ir = ADD123; step();
        if_valid = 0; byp_vld = 3'b001; byp_rc = 15'd2; byp_data = 96'h55; #2;
        check_val("s1 id_valid", id_valid, 1);
        check_val("s1 id_a", id_a, 32'h55);
        step();
        // load-use in exec, then the load reaches write back
        idle(); if_valid = 1; if_pc = 32'h44; if_ir = ADD123; step();
        if_pc = 32'h48; byp_vld = 3'b001; byp_ld = 3'b001; byp_rc = 15'd2; #2;
        check_val("s2 id_valid", id_valid, 0);
        check_val("s2 if_ready", if_ready, 0);
        step();
        check_val("s2 stall_cnt", stall_cnt, 1);
        byp_vld = 3'b100; byp_ld = 3'b100; byp_rc = 15'd2 << 10; byp_data = 96'h77 << 64; #2;
        check_val("s2 fwd id_valid", id_valid, 1);
        check_val("s2 fwd id_a", id_a, 32'h77);
        step();
        idle(); step();
        // BEQ taken then BNE not taken on R0
        if_valid = 1; if_pc = 32'h100; if_ir = BEQ_M1; step();
        if_pc = 32'h104; if_ir = BNE_M1; #2;
        check_val("s3 beq redirect_vld", redirect_vld, 1);
        check_val("s3 beq redirect_pc", redirect_pc, 32'h100);
        step();
        if_valid = 0; #2;
        check_val("s3 bne redirect_vld", redirect_vld, 0);
        step();
        // irq while stalled
        if_valid = 1; if_pc = 32'h200; if_ir = ADD123; step();
        if_pc = 32'h204; byp_vld = 3'b001; byp_ld = 3'b001; byp_rc = 15'd2; irq = 1; step();
        irq = 0; byp_vld = '0; byp_ld = '0; #2;
        check_val("s4 id_ir", id_ir, EXC_IR);
        check_val("s4 exc", id_ctl.exc, 1);
        step();
        if_valid = 0; #2;
        check_val("s4 next id_ir", id_ir, ADD123);
        check_val("s4 next exc", id_ctl.exc, 0);
        step();
        // flush with a same-cycle offer and a pending stall
        if_valid = 1; if_pc = 32'h300; if_ir = ADD123; step();
        if_pc = 32'h304; if_ir = ADD777; flush = 1; byp_vld = 3'b001; byp_ld = 3'b001; byp_rc = 15'd2; #2;
        check_val("s5 id_valid", id_valid, 0);
        check_val("s5 if_ready", if_ready, 0);
        step();
        idle(); #2;
        check_val("s5 after id_valid", id_valid, 0);
        step();
        // illegal opcode, then reset in the middle of a stall
        if_valid = 1; if_pc = 32'h400; if_ir = 32'h0; step();
        if_valid = 0; #2;
        check_val("s6 id_ir", id_ir, EXC_IR);
        check_val("s6 illegal", id_ctl.illegal, 1);
        step();
        if_valid = 1; if_pc = 32'h500; if_ir = ADD123; step();
        if_valid = 0; byp_vld = 3'b001; byp_ld = 3'b001; byp_rc = 15'd2; step();
        do_reset();
        idle();
        for (int n = 0; n < 4000; n++) begin
            rand_in();
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
